// File: rtl/seg_scan_controller.sv
// Multiplexed BCD digit scanner with dead-time between digits and a frame-synchronous
// shadow/active double buffer feeding one shared 7-segment decoder.
//
// state | meaning
// OFF   | display dark, waiting for enable
// BLANK | all digits off for BLANK_CYCLES before the next digit
// SCAN  | one digit driven for DIGIT_CYCLES
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      blank_lz,
  output logic [3:0]                bcd_out,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      update_pending,
  output logic                      frame_done
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {OFF, BLANK, SCAN} state_t;

  state_t                    state;
  logic [4*NUM_DIGITS-1:0]   shadow;
  logic [4*NUM_DIGITS-1:0]   active;
  logic [IW-1:0]             index;
  logic [CW-1:0]             cnt;

  logic [NUM_DIGITS-1:0]     lead_zero;
  logic                      run_zero;
  logic [3:0]                cur_digit;
  logic [3:0]                eff_digit;

  // lead_zero[i] is set when digit i and every more significant digit are zero
  always_comb begin
    cur_digit = 4'h0;
    run_zero  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero     = run_zero && (active[4*i +: 4] == 4'h0);
      lead_zero[i] = run_zero;
      if (index == IW'(i)) cur_digit = active[4*i +: 4];
    end
    eff_digit = (blank_lz && (index != '0) && lead_zero[index]) ? 4'hF : cur_digit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= OFF;
      shadow         <= '0;
      active         <= '0;
      index          <= '0;
      cnt            <= '0;
      bcd_out        <= 4'hF;
      digit_en       <= '0;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // While dark a load bypasses the shadow so the next frame starts with it
      if (load) begin
        shadow <= digits_in;
        if (state == OFF) begin
          active         <= digits_in;
          update_pending <= 1'b0;
        end else begin
          update_pending <= 1'b1;
        end
      end

      if (!enable) begin
        state    <= OFF;
        index    <= '0;
        cnt      <= '0;
        digit_en <= '0;
        bcd_out  <= 4'hF;
      end else begin
        case (state)
          OFF: begin
            state    <= BLANK;
            index    <= '0;
            cnt      <= '0;
            digit_en <= '0;
            bcd_out  <= 4'hF;
          end
          BLANK: begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
              state    <= SCAN;
              cnt      <= '0;
              digit_en <= EN_ONE << index;
              bcd_out  <= eff_digit;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SCAN: begin
            if (cnt == CW'(DIGIT_CYCLES - 1)) begin
              state    <= BLANK;
              cnt      <= '0;
              digit_en <= '0;
              bcd_out  <= 4'hF;
              if (index == IW'(NUM_DIGITS - 1)) begin
                index          <= '0;
                frame_done     <= 1'b1;
                active         <= shadow;
                update_pending <= load;
              end else begin
                index <= index + IW'(1);
              end
            end else begin
              cnt     <= cnt + CW'(1);
              bcd_out <= eff_digit;
            end
          end
          default: begin
            state    <= OFF;
            digit_en <= '0;
            bcd_out  <= 4'hF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Testbench for seg_scan_controller: frame-position reference model plus directed
// scenario checks and a randomized run.
module tb_seg_scan_controller;

  localparam int N     = 4;
  localparam int DC    = 4;
  localparam int BC    = 1;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = N * SLOT;

  logic           clk = 1'b0;
  logic           rst, enable, load, blank_lz;
  logic [4*N-1:0] digits_in;
  logic [3:0]     bcd_out;
  logic [N-1:0]   digit_en;
  logic           update_pending, frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_controller #(.NUM_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
    .blank_lz(blank_lz), .bcd_out(bcd_out), .digit_en(digit_en),
    .update_pending(update_pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: position m_p counts cycles since scanning started
  bit             m_on;
  int             m_p;
  logic [4*N-1:0] m_shadow, m_active;
  logic           m_pend;
  logic [3:0]     e_bcd;
  logic [N-1:0]   e_en;
  logic           e_fd;

  function automatic logic [3:0] ref_digit(logic [4*N-1:0] val, int s, logic blz);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = s; j < N; j++) if (val[4*j +: 4] != 4'h0) all_zero = 1'b0;
    if (blz && s > 0 && all_zero) return 4'hF;
    return val[4*s +: 4];
  endfunction

  function automatic int en_idx(logic [N-1:0] e);
    for (int s = 0; s < N; s++) if (e == (N'(1) << s)) return s;
    return -1;
  endfunction

  task automatic step(input logic en, input logic ld, input logic [4*N-1:0] din,
                      input logic blz, input logic rs);
    int off, s;
    rst = rs; enable = en; load = ld; digits_in = din; blank_lz = blz;
    @(posedge clk);
    e_fd = 1'b0;
    if (rs) begin
      m_on = 0; m_p = 0; m_shadow = '0; m_active = '0; m_pend = 1'b0;
    end else if (!en) begin
      if (ld) begin
        m_shadow = din;
        if (m_on) m_pend = 1'b1;
        else begin m_active = din; m_pend = 1'b0; end
      end
      m_on = 0; m_p = 0;
    end else if (!m_on) begin
      m_on = 1; m_p = 0;
      if (ld) begin m_shadow = din; m_active = din; m_pend = 1'b0; end
    end else begin
      m_p++;
      if (m_p % FRAME == 0) begin m_active = m_shadow; m_pend = 1'b0; e_fd = 1'b1; end
      if (ld) begin m_shadow = din; m_pend = 1'b1; end
    end
    e_en = '0; e_bcd = 4'hF;
    if (m_on) begin
      off = m_p % SLOT;
      s   = (m_p % FRAME) / SLOT;
      if (off >= BC) begin e_en = N'(1) << s; e_bcd = ref_digit(m_active, s, blz); end
    end
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, '0, 0, 1);
    checks++;
    if ({bcd_out, digit_en, update_pending, frame_done} !== {4'hF, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got bcd=%h en=%b pend=%b fd=%b want F/0000/0/0", bcd_out, digit_en, update_pending, frame_done);
    end
    step(0, 0, '0, 0, 0);
    checks++;
    if (digit_en !== 4'b0000 || bcd_out !== 4'hF) begin
      errors++; $display("FAIL reset_idle got bcd=%h en=%b want F/0000", bcd_out, digit_en);
    end
  endtask

  task automatic test_no_load();
    int fd_last, fd_cnt;
    fd_last = -1; fd_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      step(1, 0, '0, 0, 0);
      checks++;
      if ({bcd_out, digit_en, update_pending, frame_done} !== {e_bcd, e_en, m_pend, e_fd}) begin
        errors++; $display("FAIL noload_model c=%0d got %h/%b/%b/%b want %h/%b/%b/%b", c, bcd_out, digit_en, update_pending, frame_done, e_bcd, e_en, m_pend, e_fd);
      end
      if (c == 0 || c == 1 || c == 5 || c == 6) begin
        checks++;
        if (digit_en !== ((c == 1) ? 4'b0001 : (c == 6) ? 4'b0010 : 4'b0000)) begin
          errors++; $display("FAIL noload_seq c=%0d got en=%b", c, digit_en);
        end
      end
      if (digit_en != 0) begin
        checks++;
        if (bcd_out !== 4'h0) begin errors++; $display("FAIL noload_zero c=%0d got bcd=%h want 0", c, bcd_out); end
      end
      if (frame_done) begin
        if (fd_last >= 0) begin
          checks++;
          if (c - fd_last != FRAME) begin errors++; $display("FAIL noload_period got %0d want %0d", c - fd_last, FRAME); end
        end
        fd_last = c; fd_cnt++;
      end
    end
    checks++;
    if (fd_cnt != 2) begin errors++; $display("FAIL noload_fd_count got %0d want 2", fd_cnt); end
  endtask

  task automatic test_off_load();
    logic [15:0] want;
    int s;
    want = 16'h1234;
    step(0, 0, '0, 0, 0);
    step(0, 1, want, 0, 0);
    for (int c = 0; c < 21; c++) begin
      step(1, 0, '0, 0, 0);
      checks++;
      if ({bcd_out, digit_en, update_pending, frame_done} !== {e_bcd, e_en, m_pend, e_fd}) begin
        errors++; $display("FAIL offload_model c=%0d got %h/%b/%b/%b want %h/%b/%b/%b", c, bcd_out, digit_en, update_pending, frame_done, e_bcd, e_en, m_pend, e_fd);
      end
      checks++;
      if (update_pending !== 1'b0) begin errors++; $display("FAIL offload_pending c=%0d got %b want 0", c, update_pending); end
      if (digit_en != 0) begin
        s = en_idx(digit_en);
        checks++;
        if (s < 0) begin errors++; $display("FAIL offload_onehot got en=%b", digit_en); end
        else if (bcd_out !== want[4*s +: 4]) begin errors++; $display("FAIL offload_digit s=%0d got %h want %h", s, bcd_out, want[4*s +: 4]); end
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [15:0] want;
    int s, guard;
    bit seen_fd;
    guard = 0;
    while (m_p % FRAME != 7 && guard < 40) begin step(1, 0, '0, 0, 0); guard++; end
    step(1, 1, 16'h5678, 0, 0);
    checks++;
    if (update_pending !== 1'b1) begin errors++; $display("FAIL mid_pending got %b want 1", update_pending); end
    want = 16'h1234; seen_fd = 0;
    for (int c = 0; c < 40 && !seen_fd; c++) begin
      step(1, 0, '0, 0, 0);
      checks++;
      if ({bcd_out, digit_en, update_pending, frame_done} !== {e_bcd, e_en, m_pend, e_fd}) begin
        errors++; $display("FAIL mid_model c=%0d got %h/%b/%b/%b want %h/%b/%b/%b", c, bcd_out, digit_en, update_pending, frame_done, e_bcd, e_en, m_pend, e_fd);
      end
      if (frame_done) begin
        seen_fd = 1;
        checks++;
        if (update_pending !== 1'b0) begin errors++; $display("FAIL mid_clear got pend=%b want 0", update_pending); end
      end else if (digit_en != 0) begin
        s = en_idx(digit_en);
        checks++;
        if (s < 0 || bcd_out !== want[4*s +: 4]) begin errors++; $display("FAIL mid_old_digit en=%b got %h", digit_en, bcd_out); end
      end
    end
    checks++;
    if (!seen_fd) begin errors++; $display("FAIL mid_fd_timeout got none want frame_done"); end
    want = 16'h5678;
    for (int c = 0; c < FRAME - 1; c++) begin
      step(1, 0, '0, 0, 0);
      if (digit_en != 0) begin
        s = en_idx(digit_en);
        checks++;
        if (s < 0 || bcd_out !== want[4*s +: 4]) begin errors++; $display("FAIL mid_new_digit en=%b got %h", digit_en, bcd_out); end
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [15:0] vals [3];
    logic [15:0] wants [3];
    logic        blzs [3];
    logic [15:0] w;
    int s;
    vals  = '{16'h0070, 16'h0070, 16'h0000};
    wants = '{16'hFF70, 16'h0070, 16'hFFF0};
    blzs  = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, 0, 0);
      step(0, 1, vals[k], 0, 0);
      w = wants[k];
      for (int c = 0; c < FRAME + 1; c++) begin
        step(1, 0, '0, blzs[k], 0);
        checks++;
        if ({bcd_out, digit_en, update_pending, frame_done} !== {e_bcd, e_en, m_pend, e_fd}) begin
          errors++; $display("FAIL lz_model k=%0d c=%0d got %h/%b want %h/%b", k, c, bcd_out, digit_en, e_bcd, e_en);
        end
        if (digit_en != 0) begin
          s = en_idx(digit_en);
          checks++;
          if (s < 0 || bcd_out !== w[4*s +: 4]) begin errors++; $display("FAIL lz_digit k=%0d en=%b got %h", k, digit_en, bcd_out); end
        end
      end
    end
  endtask

  task automatic test_commit_collision();
    logic [15:0] want;
    int s, guard;
    guard = 0;
    while (m_p % FRAME != 3 && guard < 40) begin step(1, 0, '0, 0, 0); guard++; end
    step(1, 1, 16'h1111, 0, 0);
    guard = 0;
    while ((m_p + 1) % FRAME != 0 && guard < 40) begin step(1, 0, '0, 0, 0); guard++; end
    step(1, 1, 16'h2222, 0, 0);
    checks++;
    if (frame_done !== 1'b1 || update_pending !== 1'b1) begin
      errors++; $display("FAIL coll_commit got fd=%b pend=%b want 1/1", frame_done, update_pending);
    end
    for (int f = 0; f < 2; f++) begin
      want = (f == 0) ? 16'h1111 : 16'h2222;
      for (int c = 0; c < FRAME; c++) begin
        step(1, 0, '0, 0, 0);
        checks++;
        if ({bcd_out, digit_en, update_pending, frame_done} !== {e_bcd, e_en, m_pend, e_fd}) begin
          errors++; $display("FAIL coll_model f=%0d c=%0d got %h/%b/%b/%b want %h/%b/%b/%b", f, c, bcd_out, digit_en, update_pending, frame_done, e_bcd, e_en, m_pend, e_fd);
        end
        if (f == 0 && c < FRAME - 1) begin
          checks++;
          if (update_pending !== 1'b1) begin errors++; $display("FAIL coll_pend c=%0d got %b want 1", c, update_pending); end
        end
        if (digit_en != 0) begin
          s = en_idx(digit_en);
          checks++;
          if (s < 0 || bcd_out !== want[4*s +: 4]) begin errors++; $display("FAIL coll_digit f=%0d en=%b got %h", f, digit_en, bcd_out); end
        end
      end
    end
  endtask

  task automatic test_disable();
    int guard;
    guard = 0;
    while (digit_en !== 4'b0100 && guard < 2 * FRAME) begin step(1, 0, '0, 0, 0); guard++; end
    checks++;
    if (digit_en !== 4'b0100) begin errors++; $display("FAIL dis_reach got en=%b want 0100", digit_en); end
    step(0, 0, '0, 0, 0);
    checks++;
    if ({bcd_out, digit_en, frame_done} !== {4'hF, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL dis_off got bcd=%h en=%b fd=%b want F/0000/0", bcd_out, digit_en, frame_done);
    end
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    checks++;
    if (digit_en !== 4'b0000) begin errors++; $display("FAIL dis_reblank got en=%b want 0000", digit_en); end
    step(1, 0, '0, 0, 0);
    checks++;
    if (digit_en !== 4'b0001 || bcd_out !== e_bcd) begin
      errors++; $display("FAIL dis_restart got en=%b bcd=%h want 0001/%h", digit_en, bcd_out, e_bcd);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    step(1, 1, 16'h9876, 0, 0);
    while (digit_en == 0 && guard < 2 * FRAME) begin step(1, 0, '0, 0, 0); guard++; end
    step(1, 0, '0, 0, 1);
    checks++;
    if ({bcd_out, digit_en, update_pending, frame_done} !== {4'hF, 4'b0000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rstmid got %h/%b/%b/%b want F/0000/0/0", bcd_out, digit_en, update_pending, frame_done);
    end
    for (int c = 0; c < FRAME + 2; c++) begin
      step(1, 0, '0, 1, 0);
      checks++;
      if ({bcd_out, digit_en, update_pending, frame_done} !== {e_bcd, e_en, m_pend, e_fd}) begin
        errors++; $display("FAIL rstmid_model c=%0d got %h/%b/%b/%b want %h/%b/%b/%b", c, bcd_out, digit_en, update_pending, frame_done, e_bcd, e_en, m_pend, e_fd);
      end
    end
  endtask

  task automatic test_random();
    logic           en, ld, blz;
    logic [4*N-1:0] din;
    for (int c = 0; c < 500; c++) begin
      en  = ($urandom_range(0, 24) != 0);
      ld  = ($urandom_range(0, 5) == 0);
      blz = ($urandom_range(0, 3) != 0);
      din = '0;
      for (int j = 0; j < N; j++)
        din[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(en, ld, din, blz, 0);
      checks++;
      if ({bcd_out, digit_en, update_pending, frame_done} !== {e_bcd, e_en, m_pend, e_fd}) begin
        errors++; $display("FAIL rand_model c=%0d got %h/%b/%b/%b want %h/%b/%b/%b", c, bcd_out, digit_en, update_pending, frame_done, e_bcd, e_en, m_pend, e_fd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; blank_lz = 1'b0; digits_in = '0;
    test_reset();
    test_no_load();
    test_off_load();
    test_midframe_load();
    test_blank_lz();
    test_commit_collision();
    test_disable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto one shared 4-bit-to-7-segment decoder and a common-segment multi-digit display.
- Sequences the digit enables with dead-time between digits to prevent ghosting.
- Double-buffers incoming digit values so a display update only takes effect at a frame boundary, which prevents tearing.
- Sits between the value-producing logic (counters, FSMs) and the shared segment decoder.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DIGIT_CYCLES, 1000, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 50, clk cycles all digits are off between consecutive digits (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  1 = scan display; 0 = display dark
load  input  1  single-cycle strobe: capture digits_in
digits_in  input  4*NUM_DIGITS  BCD digits, digit 0 = LSD in bits [3:0]
blank_lz  input  1  1 = suppress leading zeros
bcd_out  output  4  code to the shared segment decoder
digit_en  output  NUM_DIGITS  one-hot, active-high digit select
update_pending  output  1  shadow holds data not yet displayed
frame_done  output  1  one-cycle pulse at the end of each scanned frame

Behaviour:
- One clock domain (clk). rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - bcd_out=4'hF, digit_en=0, update_pending=0, frame_done=0.
  - shadow and active digit registers = 0, digit index=0, cycle counter=0.
  - State = OFF.
- States:
  - OFF: digit_en=0, bcd_out=4'hF.
    - enable=1 -> BLANK, with index=0 and counter=0.
  - BLANK: digit_en=0, bcd_out=4'hF, lasts BLANK_CYCLES cycles -> SCAN.
  - SCAN: digit_en[index]=1 only, bcd_out=effective digit[index], lasts DIGIT_CYCLES cycles.
    - At the last cycle with index<NUM_DIGITS-1: index+1, go to BLANK.
    - At the last cycle with index=NUM_DIGITS-1: index=0, frame_done=1 for the next cycle, commit, go to BLANK.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) cycles, constant.
- enable=0 in any state: the next cycle is OFF with digit_en=0, index=0, counter=0, and no frame_done.
  - Shadow, active and update_pending are retained.
- Load/commit:
  - load in BLANK/SCAN: shadow<=digits_in, update_pending<=1.
  - Commit (frame end): active<=shadow, update_pending<=0.
  - load in the same cycle as a commit: the commit uses the old shadow; shadow takes the new value; update_pending stays 1.
  - load while already pending: shadow is overwritten (last write wins), update_pending stays 1.
  - load in OFF: active and shadow both <=digits_in next cycle; update_pending stays 0.
- Effective digit:
  - blank_lz=1: digit i is replaced by 4'hF if active digit i and all more significant digits equal 0. Digit 0 is never blanked.
  - blank_lz=0: active value is passed unchanged.
  - Values 10..15 pass through unchanged; the decoder blanks them.
  - blank_lz is sampled live each cycle, not buffered.
- digit_en is never multi-hot. At least BLANK_CYCLES all-zero cycles separate any two different digit enables.

Test Plan:
(Parameters unless noted: NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=1.)
- Reset, then enable=1 with no load.
  - Expect digit_en sequence: 0000 for 1 cycle, then 0001 x4, 0000 x1, 0010 x4, and so on up to 1000.
  - bcd_out=0 during every SCAN phase.
  - frame_done pulses once every 20 cycles.
- load with digits_in=16'h1234 while in OFF, then enable=1.
  - Expect bcd_out 4,3,2,1 with digit_en 0001,0010,0100,1000.
  - update_pending stays 0 throughout.
- While scanning 1234, load 16'h5678 mid-frame.
  - Expect update_pending=1 and the remaining digits still from 1234.
  - The next frame shows 8,7,6,5; update_pending clears in the cycle frame_done rises.
- Active value 16'h0070 with blank_lz=1.
  - Expect bcd_out F,F,7,0 for digits 3..0.
  - Active value 16'h0000: expect F,F,F,0.
  - With blank_lz=0: expect 0,0,7,0.
- load at the exact commit cycle while pending=1 with shadow=16'h1111, loading 16'h2222.
  - Next frame shows 1111, update_pending stays 1.
  - The following frame shows 2222.
- Drop enable during SCAN of digit 2.
  - Next cycle digit_en=0 and no frame_done.
  - Re-enable: scanning restarts at BLANK, then digit 0.
  - Assert rst mid-SCAN: all outputs take their reset values next cycle.
